muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide unit.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs iterative shift-add multiply or restoring divide over 32 cycles.
- Stalls the pipeline while computing, then issues one write-enable pulse to HI and LO.
- Sits beside the ALU. Its hi_wena/lo_wena/hi_out/lo_out feed the HI/LO register file in parallel with the write-back path.

Parameters:
FAST_MUL, 0, 1 = multiply finishes in a single CALC cycle using a full 32x32 product; 0 = 32 iterative cycles. Divide is always iterative.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  32  multiplicand / dividend (rs)
b  in  32  multiplier / divisor (rt)
flush  in  1  abort in-flight operation (branch/exception)
busy  out  1  state != IDLE
stall_req  out  1  hold IF/ID/EX
done  out  1  one-cycle result-valid pulse
hi_wena  out  1  HI write enable
lo_wena  out  1  LO write enable
hi_out  out  32  HI result
lo_out  out  32  LO result
div_by_zero  out  1  valid with done; set for DIV/DIVU with b==0

Behaviour:
- All state updates occur on the rising edge of clk. rst is synchronous and active-high and has priority over every other input.
- Reset values:
  - state = IDLE.
  - busy, stall_req, done, hi_wena, lo_wena, div_by_zero = 0.
  - hi_out, lo_out = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 at edge E0: latch op, |a|, |b| (absolute value only for signed ops), result signs and b==0; count=0; go to CALC.
  - start with flush=1: ignored.
- CALC:
  - One iteration per edge; count increments.
  - After the 32nd iteration (edge E32), or after E1 when FAST_MUL=1 and op is a multiply, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, hi_wena=lo_wena=~flush.
  - Next edge: go to IDLE.
  - A new start may be accepted on the edge that leaves DONE only if it is sampled in IDLE; a start is never sampled in DONE.
- stall_req = (state==IDLE & start & ~flush) | state==CALC.
  - It is combinational, so the requesting instruction freezes in EX from the cycle it is presented.
  - It is deasserted in DONE, so the pipeline advances in the same cycle the result is written.
- Latency: start edge E0 -> done high in cycle after E32 (33 cycles). FAST_MUL multiply: done in cycle after E1.
- Multiply: 64-bit unsigned product of magnitudes. MULT negates the product if sign(a)^sign(b). HI=product[63:32], LO=product[31:0].
- Divide: restoring unsigned divide of magnitudes.
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a.
  - LO = quotient, HI = remainder.
  - 0x80000000 / -1 (DIV) yields LO=0x80000000, HI=0; no trap.
- Divide by zero:
  - No iteration shortcut; full latency still applies.
  - LO=0xFFFFFFFF, HI=a (original, unmodified), div_by_zero=1 for the done cycle.
- hi_out/lo_out hold the last completed result until the next DONE. div_by_zero is 0 outside DONE.
- flush:
  - In CALC: go to IDLE next edge; no write; hi_out/lo_out unchanged.
  - In DONE: writes are suppressed; state goes to IDLE.
- start while busy: ignored; it does not queue.
- rst mid-operation: IDLE next edge; no write pulse; outputs take their reset values.

Test Plan:
1. MULTU a=0xFFFFFFFF b=2 -> done 33 cycles after start; HI=0x00000001, LO=0xFFFFFFFE; one hi_wena/lo_wena pulse; stall_req high for cycles 0..32 and low in the done cycle.
2. MULT a=-3 b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat with FAST_MUL=1 -> same values, done in cycle 2.
3. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU a=100 b=0 -> after 33 cycles, div_by_zero=1, LO=0xFFFFFFFF, HI=0x00000064.
5. DIVU 100/7 started, flush at cycle 10 -> no wena, busy=0 in cycle 11, hi_out/lo_out keep prior values. New MULTU 6*7 -> LO=42, HI=0.
6. Second start pulsed at cycle 5 of a divide -> ignored, exactly one done. rst at cycle 20 -> IDLE, all outputs 0, no write pulse.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> HI/LO multiply/divide sequencer handshake and result bus.
// The execute stage holds the master side; the sequencer holds the slave side.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic        hi_wena;
  logic        lo_wena;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall_req, done, hi_wena, lo_wena, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall_req, done, hi_wena, lo_wena, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide, one HI/LO write per op.
// Latency 33 cycles start->done (2 for FAST_MUL multiply); stall_req holds the pipeline, start ignored while busy.
module muldiv_seq #(
  parameter bit FAST_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] opa, opb;
  logic        neg_q, neg_r, bz;
  logic [4:0]  count;
  logic [63:0] acc, acc_nxt;
  logic [31:0] hi_q, lo_q;
  logic        accept, last, is_div;

  logic        sgn_in;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod;
  logic [31:0] quo, rem, res_hi, res_lo;

  assign is_div = op_q[1];
  assign sgn_in = ~bus.op[0];
  assign a_mag  = (sgn_in && bus.a[31]) ? -bus.a : bus.a;
  assign b_mag  = (sgn_in && bus.b[31]) ? -bus.b : bus.b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = is_div ? (count == 5'd31) : (FAST_MUL || count == 5'd31);
    unique case (state)
      IDLE: if (bus.start && !bus.flush) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (bus.flush)  state_nxt = IDLE;
            else if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    bus.busy        = (state != IDLE);
    bus.stall_req   = (state == IDLE && bus.start && !bus.flush) || (state == CALC);
    bus.done        = (state == DONE);
    bus.hi_wena     = (state == DONE) && !bus.flush;
    bus.lo_wena     = (state == DONE) && !bus.flush;
    bus.div_by_zero = (state == DONE) && is_div && bz;
    bus.hi_out      = hi_q;
    bus.lo_out      = lo_q;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    rem_sh   = acc[63:31];
    div_ge   = (rem_sh >= {1'b0, opb});
    div_diff = rem_sh[31:0] - opb;
    if (is_div)
      acc_nxt = div_ge ? {div_diff, acc[30:0], 1'b1} : {rem_sh[31:0], acc[30:0], 1'b0};
    else if (FAST_MUL)
      acc_nxt = {32'd0, opa} * {32'd0, opb};
    else
      acc_nxt = {mul_sum, acc[31:1]};

    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[31:0] : acc_nxt[31:0];
    rem  = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];
    if (is_div) begin
      res_hi = rem;
      res_lo = bz ? 32'hFFFF_FFFF : quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= 2'b00;
      opa   <= 32'd0;
      opb   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz    <= 1'b0;
      count <= 5'd0;
      acc   <= 64'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else if (accept) begin
      op_q  <= bus.op;
      opa   <= a_mag;
      opb   <= b_mag;
      neg_q <= sgn_in && (bus.a[31] ^ bus.b[31]);
      neg_r <= sgn_in && bus.a[31];
      bz    <= (bus.b == 32'd0);
      count <= 5'd0;
      acc   <= {32'd0, bus.op[1] ? a_mag : b_mag};
    end else if (state == CALC && !bus.flush) begin
      count <= count + 5'd1;
      acc   <= acc_nxt;
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, random ops against a reference model,
// and hand sequences for flush, busy-start, reset and FAST_MUL timing.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush, sel_fast;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req, done, hi_wena, lo_wena, dbz;
  logic [31:0] hi_out, lo_out;

  muldiv_seq_if ms();
  muldiv_seq_if mf();

  assign ms.start = start & ~sel_fast;
  assign mf.start = start & sel_fast;
  assign ms.op = op;    assign mf.op = op;
  assign ms.a = a;      assign mf.a = a;
  assign ms.b = b;      assign mf.b = b;
  assign ms.flush = flush;
  assign mf.flush = flush;

  assign busy      = sel_fast ? mf.busy        : ms.busy;
  assign stall_req = sel_fast ? mf.stall_req   : ms.stall_req;
  assign done      = sel_fast ? mf.done        : ms.done;
  assign hi_wena   = sel_fast ? mf.hi_wena     : ms.hi_wena;
  assign lo_wena   = sel_fast ? mf.lo_wena     : ms.lo_wena;
  assign dbz       = sel_fast ? mf.div_by_zero : ms.div_by_zero;
  assign hi_out    = sel_fast ? mf.hi_out      : ms.hi_out;
  assign lo_out    = sel_fast ? mf.lo_out      : ms.lo_out;

  muldiv_seq #(.FAST_MUL(1'b0)) dut   (.clk(clk), .rst(rst), .bus(ms));
  muldiv_seq #(.FAST_MUL(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(mf));

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  int          n_checks = 0, n_err = 0;
  int          wena_cnt = 0, lo_cnt = 0, done_cnt = 0;
  logic [31:0] last_hi = 32'd0, last_lo = 32'd0;

  always @(negedge clk) begin
    #3;
    if (hi_wena) wena_cnt++;
    if (lo_wena) lo_cnt++;
    if (done)    done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib);
    longint sa, sb_, p, q, r;
    exp_t   e;
    sa  = o[0] ? $signed({32'd0, ia}) : $signed({{32{ia[31]}}, ia});
    sb_ = o[0] ? $signed({32'd0, ib}) : $signed({{32{ib[31]}}, ib});
    e.dbz = 1'b0;
    if (!o[1]) begin
      p = sa * sb_;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (ib == 32'd0) begin
      e.dbz = 1'b1;
      e.hi  = ia;
      e.lo  = 32'hFFFF_FFFF;
    end else begin
      q = sa / sb_;
      r = sa % sb_;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int lat, input int extra, input logic fl_done, input string nm);
    int   cyc, w0, l0, d0;
    logic got, stall_ok;
    exp_t e;
    w0 = wena_cnt; l0 = lo_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    #1 chk1({nm, "_stall_req_at_start"}, stall_req, 1'b1);
    sb.push_back('{ehi, elo, edbz});
    cyc = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra);
      #1;
      if (done) got = 1'b1;
      else if (!stall_req || !busy) stall_ok = 1'b0;
    end
    e = sb.pop_front();
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, required at cycle %0d", nm, cyc, lat);
    end else begin
      chk1({nm, "_stall_busy_in_calc"}, stall_ok, 1'b1);
      chk({nm, "_latency"}, cyc, lat);
      chk1({nm, "_stall_req_in_done"}, stall_req, 1'b0);
      if (fl_done) begin
        flush = 1'b1;
        #1;
        chk1({nm, "_hi_wena_flushed"}, hi_wena, 1'b0);
        chk1({nm, "_lo_wena_flushed"}, lo_wena, 1'b0);
      end else begin
        chk({nm, "_hi"}, hi_out, e.hi);
        chk({nm, "_lo"}, lo_out, e.lo);
        chk1({nm, "_div_by_zero"}, dbz, e.dbz);
        chk1({nm, "_hi_wena"}, hi_wena, 1'b1);
        chk1({nm, "_lo_wena"}, lo_wena, 1'b1);
        last_hi = e.hi;
        last_lo = e.lo;
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk1({nm, "_busy_after"}, busy, 1'b0);
      chk1({nm, "_dbz_after"}, dbz, 1'b0);
      chk({nm, "_hi_wena_pulses"}, wena_cnt - w0, fl_done ? 0 : 1);
      chk({nm, "_lo_wena_pulses"}, lo_cnt - l0, fl_done ? 0 : 1);
      chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_stall_req"}, stall_req, 1'b0);
    chk1({nm, "_done"}, done, 1'b0);
    chk1({nm, "_hi_wena"}, hi_wena, 1'b0);
    chk1({nm, "_lo_wena"}, lo_wena, 1'b0);
    chk1({nm, "_div_by_zero"}, dbz, 1'b0);
    chk({nm, "_hi_out"}, hi_out, 32'd0);
    chk({nm, "_lo_out"}, lo_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0, d0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    exp_t        m;

    vecs[0] = '{MULTU, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{DIVU,  32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
    vecs[6] = '{MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{DIV,   32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{DIV,   32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{MULT,  32'hFFFF_FFFF, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 32'h8000_0001, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; sel_fast = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    #1 check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
             33, -1, 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      m  = model(ro, ra, rb);
      run_op(ro, ra, rb, m.hi, m.lo, m.dbz, 33, -1, 1'b0, $sformatf("rand%0d", i));
    end

    // Flush during CALC: abort with no write, results unchanged.
    w0 = wena_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk1("flush_calc_busy", busy, 1'b0);
    chk("flush_calc_hi_kept", hi_out, last_hi);
    chk("flush_calc_lo_kept", lo_out, last_lo);
    repeat (40) @(negedge clk);
    chk("flush_calc_wena_pulses", wena_cnt - w0, 0);
    chk("flush_calc_done_pulses", done_cnt - d0, 0);
    run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, -1, 1'b0, "after_flush");

    // Start pulsed while busy must not queue a second operation.
    run_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 5, 1'b0, "start_busy");
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("start_busy_no_second_done", done_cnt - d0, 0);

    // Flush in the DONE cycle suppresses the write pulses.
    run_op(DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 33, -1, 1'b1, "flush_done");
    run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, -1, 1'b0, "after_flush_done");

    // Reset mid-operation.
    w0 = wena_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_idle_zero("rst_mid");
    repeat (40) @(negedge clk);
    chk("rst_mid_wena_pulses", wena_cnt - w0, 0);
    chk("rst_mid_done_pulses", done_cnt - d0, 0);

    // FAST_MUL instance: multiply in one CALC cycle, divide still iterative.
    sel_fast = 1'b1;
    run_op(MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2, -1, 1'b0, "fast_mult");
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2, -1, 1'b0, "fast_multu");
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1, 1'b0, "fast_div");
    sel_fast = 1'b0;

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
